// File: rtl/seq_pkg.sv
// Shared types and width helpers for the drum step sequencer.
package seq_pkg;

    // Sequencer top-level state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Width of a step index; never narrower than one bit.
    function automatic int step_w(input int num_steps);
        return (num_steps > 1) ? $clog2(num_steps) : 1;
    endfunction

    // Width of a voice index; never narrower than one bit.
    function automatic int voice_w(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

endpackage

// File: rtl/trig_stretcher.sv
// Per-voice trigger stretcher: a fire loads TRIG_CYCLES into a down-counter
// and the trigger output is high while the counter is nonzero. A fire on a
// voice that is still high reloads the counter, so the pulse has no gap.
module trig_stretcher #(
    parameter int TRIG_CYCLES = 4
) (
    input  logic mclk,
    input  logic rst,
    input  logic clr,
    input  logic fire,
    output logic trig_out
);

    localparam int CNT_W = $clog2(TRIG_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next counter value: clear wins, then reload on fire, else count down.
    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = CNT_W'(TRIG_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register; asynchronous reset drops the trigger immediately.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign trig_out = (cnt_q != '0);

endmodule

// File: rtl/drum_step_sequencer.sv
// Pattern-driven trigger initiator for the oneshot drum sources.
// Holds a per-voice step pattern, advances one step every latched period of
// mclk cycles while run is high, and fires a stretched trigger on each voice
// whose pattern bit is set and whose mute bit is clear.
// Optional build macro SEQ_SWING_EN adds a swing input that delays odd steps.
module drum_step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int NUM_STEPS   = 16,
    parameter int PERIOD_BITS = 24,
    parameter int TRIG_CYCLES = 4
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [PERIOD_BITS-1:0]        step_period,
`ifdef SEQ_SWING_EN
    input  logic [PERIOD_BITS-1:0]        swing,
`endif
    input  logic [NUM_VOICES-1:0]         mute,
    input  logic                          pat_we,
    input  logic [voice_w(NUM_VOICES)-1:0] pat_voice,
    input  logic [step_w(NUM_STEPS)-1:0]  pat_step,
    input  logic                          pat_bit,
    output logic [NUM_VOICES-1:0]         trig,
    output logic [step_w(NUM_STEPS)-1:0]  step_idx,
    output logic                          step_strobe,
    output logic                          running
);

    localparam int STEP_W  = step_w(NUM_STEPS);
    localparam int VOICE_W = voice_w(NUM_VOICES);
`ifdef SEQ_SWING_EN
    // An odd step can sit period+swing cycles out, which needs one extra bit.
    localparam int CNT_W = PERIOD_BITS + 1;
`else
    localparam int CNT_W = PERIOD_BITS;
`endif

    seq_state_t                           state_q, state_d;
    logic [CNT_W-1:0]                     tick_q, tick_d;
    logic [STEP_W-1:0]                    step_q, step_d;
    logic [STEP_W-1:0]                    fire_step;
    logic [PERIOD_BITS-1:0]               period_q, period_d;
    logic [PERIOD_BITS-1:0]               period_eff;
    logic                                 strobe_q, strobe_d;
    logic                                 fire;
    logic                                 clear;
    logic [CNT_W-1:0]                     interval;
    logic [NUM_VOICES-1:0][NUM_STEPS-1:0] pattern_q, pattern_d;
    logic [NUM_VOICES-1:0]                voice_fire;
    logic                                 voice_ok;

    // A zero period behaves like one: a step every cycle.
    assign period_eff = (step_period == '0) ? PERIOD_BITS'(1) : step_period;

`ifdef SEQ_SWING_EN
    logic [PERIOD_BITS-1:0] swing_q, swing_d;
    logic [PERIOD_BITS-1:0] swing_max;

    assign swing_max = period_eff - PERIOD_BITS'(1);

    // Gap to the next step: long after an even step, short after an odd one.
    always_comb begin
        interval = {1'b0, period_q};
        if (!step_q[0]) begin
            interval = {1'b0, period_q} + {1'b0, swing_q};
        end else if (period_q > swing_q) begin
            interval = {1'b0, period_q - swing_q};
        end else begin
            interval = CNT_W'(1);
        end
    end

    // Swing is captured at even step fires, clamped below the new period.
    always_comb begin
        swing_d = swing_q;
        if (fire && !fire_step[0]) begin
            swing_d = (swing > swing_max) ? swing_max : swing;
        end
    end

    // Latched swing register.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            swing_q <= '0;
        end else begin
            swing_q <= swing_d;
        end
    end
`else
    assign interval = period_q;
`endif

    // FSM next state, tick counter, step index and step fire decision.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        step_d    = step_q;
        period_d  = period_q;
        strobe_d  = 1'b0;
        fire      = 1'b0;
        clear     = 1'b0;
        fire_step = step_q + STEP_W'(1);
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d   = RUN;
                    fire      = 1'b1;
                    fire_step = '0;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                    tick_d  = '0;
                    step_d  = '0;
                end else if (tick_q == interval - CNT_W'(1)) begin
                    fire = 1'b1;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (fire) begin
            tick_d   = '0;
            step_d   = fire_step;
            strobe_d = 1'b1;
            period_d = period_eff;
        end
    end

    // Writes to voices beyond NUM_VOICES are dropped when the index can reach them.
    if ((1 << VOICE_W) > NUM_VOICES) begin : g_voice_chk
        assign voice_ok = ({1'b0, pat_voice} < (VOICE_W + 1)'(NUM_VOICES));
    end else begin : g_voice_all
        assign voice_ok = 1'b1;
    end

    // Pattern update; the fire on the same edge reads the old contents.
    always_comb begin
        pattern_d = pattern_q;
        if (pat_we && voice_ok) begin
            pattern_d[pat_voice][pat_step] = pat_bit;
        end
    end

    // Sequencer state, counters and pattern storage.
    // NOTE: the pattern store is reset too, since a reset must leave it all zeros.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            step_q    <= '0;
            period_q  <= '0;
            strobe_q  <= 1'b0;
            pattern_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            period_q  <= period_d;
            strobe_q  <= strobe_d;
            pattern_q <= pattern_d;
        end
    end

    // One stretcher per voice, fired by pattern bit and mute at this edge.
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign voice_fire[v] = fire && pattern_q[v][fire_step] && !mute[v];

        trig_stretcher #(
            .TRIG_CYCLES(TRIG_CYCLES)
        ) u_stretch (
            .mclk    (mclk),
            .rst     (rst),
            .clr     (clear),
            .fire    (voice_fire[v]),
            .trig_out(trig[v])
        );
    end

    assign step_idx    = step_q;
    assign step_strobe = strobe_q;
    assign running     = (state_q == RUN);

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer: directed scenarios plus
// randomized stimulus, all checked against an event-time reference model.
module tb_drum_step_sequencer;

    localparam int NV = 4;
    localparam int NS = 16;
    localparam int PB = 24;
    localparam int TC = 4;

    logic          mclk = 1'b0;
    logic          rst  = 1'b0;
    logic          run  = 1'b0;
    logic [PB-1:0] step_period = '0;
`ifdef SEQ_SWING_EN
    logic [PB-1:0] swing = '0;
`endif
    logic [NV-1:0] mute = '0;
    logic          pat_we = 1'b0;
    logic [1:0]    pat_voice = '0;
    logic [3:0]    pat_step = '0;
    logic          pat_bit = 1'b0;
    logic [NV-1:0] trig;
    logic [3:0]    step_idx;
    logic          step_strobe;
    logic          running;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: absolute edge times of the next step and of each
    // voice's pulse end, rather than counters.
    longint        cyc = 0;
    bit            m_run;
    int            m_step;
    longint        m_next;
    longint        m_until [NV];
    bit            m_strobe;
    bit            m_pat [NV][NS];
    int            m_period;
    int            m_swing;
    logic [NV-1:0] m_trig;

    // Scratch for directed scenarios.
    int     offs_q[$];
    int     e0, cnt, wraps, hits, ph;
    bit     prev, done, unmuted;
    int     exp_kick[5]   = '{1, 41, 81, 121, 161};
    int     exp_strobe[3] = '{1, 11, 21};

    drum_step_sequencer dut (
        .mclk       (mclk),
        .rst        (rst),
        .run        (run),
        .step_period(step_period),
`ifdef SEQ_SWING_EN
        .swing      (swing),
`endif
        .mute       (mute),
        .pat_we     (pat_we),
        .pat_voice  (pat_voice),
        .pat_step   (pat_step),
        .pat_bit    (pat_bit),
        .trig       (trig),
        .step_idx   (step_idx),
        .step_strobe(step_strobe),
        .running    (running)
    );

    always #5 mclk = ~mclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_period(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_reset();
        m_run = 0; m_step = 0; m_next = 0; m_strobe = 0;
        m_period = 0; m_swing = 0; m_trig = '0;
        for (int v = 0; v < NV; v++) begin
            m_until[v] = 0;
            for (int s = 0; s < NS; s++) m_pat[v][s] = 0;
        end
    endtask

    // Apply the sequencer rules for the edge numbered cyc using current inputs.
    task automatic model_edge();
        bit     fire = 0;
        int     s = 0;
        longint gap;
        m_strobe = 0;
        if (!m_run) begin
            if (run) begin
                fire = 1; s = 0; m_run = 1;
            end
        end else if (!run) begin
            m_run = 0; m_step = 0;
            for (int v = 0; v < NV; v++) m_until[v] = 0;
        end else if (cyc == m_next) begin
            fire = 1; s = (m_step + 1) % NS;
        end
        if (fire) begin
            m_step   = s;
            m_strobe = 1;
            m_period = eff_period(int'(step_period));
            gap      = m_period;
`ifdef SEQ_SWING_EN
            if (s % 2 == 0) m_swing = (int'(swing) > m_period - 1) ? m_period - 1 : int'(swing);
            if (s % 2 == 0) gap = m_period + m_swing;
            else            gap = (m_period > m_swing) ? m_period - m_swing : 1;
`endif
            m_next = cyc + gap;
            for (int v = 0; v < NV; v++)
                if (m_pat[v][s] && !mute[v]) m_until[v] = cyc + TC;
        end
        if (pat_we && int'(pat_voice) < NV) m_pat[pat_voice][pat_step] = pat_bit;
        for (int v = 0; v < NV; v++) m_trig[v] = (cyc < m_until[v]);
        cyc++;
    endtask

    task automatic compare_all();
        check("trig", trig, m_trig);
        check("step_idx", step_idx, m_step);
        check("step_strobe", step_strobe, m_strobe);
        check("running", running, m_run);
    endtask

    // One mclk edge: model it, check outputs 1 time unit later, drop the write strobe.
    task automatic tick();
        @(posedge mclk);
        model_edge();
        #1;
        compare_all();
        pat_we = 1'b0;
    endtask

    task automatic write_pat(input int v, input int s, input bit b);
        pat_we = 1'b1; pat_voice = 2'(v); pat_step = 4'(s); pat_bit = b;
        tick();
    endtask

    initial begin
        model_reset();
        // Reset state.
        #1 rst = 1'b1;
        #1;
        check("reset_trig", trig, '0);
        check("reset_step_idx", step_idx, '0);
        check("reset_strobe", step_strobe, 1'b0);
        check("reset_running", running, 1'b0);
        @(posedge mclk);
        #2 rst = 1'b0;

        // Voice0 on steps 0,4,8,12 at period 10; voice1 on step 5 for the stop test.
        step_period = PB'(10);
        write_pat(0, 0, 1); write_pat(0, 4, 1); write_pat(0, 8, 1); write_pat(0, 12, 1);
        write_pat(1, 5, 1);
        run = 1'b1;
        e0 = int'(cyc);
        prev = 0;
        offs_q.delete();
        for (int i = 0; i < 170; i++) begin
            tick();
            if (trig[0] && !prev) offs_q.push_back(int'(cyc) - e0);
            prev = trig[0];
            if (step_strobe && i < 30) cnt = int'(cyc) - e0;
            if (i == 0 || i == 10 || i == 20) check($sformatf("strobe_at_%0d", exp_strobe[i/10]), {63'd0, step_strobe}, 64'd1);
        end
        for (int i = 0; i < 5; i++)
            check($sformatf("kick_rise_%0d", i), (i < offs_q.size()) ? offs_q[i] : -1, exp_kick[i]);

        // Drop run at step 5 mid-pulse, then restart.
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (step_strobe && step_idx == 4'd5) done = 1;
        end
        check("stop_reached_step5", done, 1);
        check("stop_pre_trig1", trig[1], 1);
        run = 1'b0;
        tick();
        check("stop_trig", trig, '0);
        check("stop_running", running, 0);
        check("stop_step_idx", step_idx, 0);
        run = 1'b1;
        tick();
        check("restart_strobe", step_strobe, 1);
        check("restart_step_idx", step_idx, 0);

        // Period 0 with voice1 all ones: continuous trigger, step every cycle.
        run = 1'b0;
        tick();
        step_period = '0;
        for (int s = 0; s < NS; s++) write_pat(1, s, 1);
        run = 1'b1;
        cnt = 0; wraps = 0;
        tick();
        for (int i = 1; i < 40; i++) begin
            prev = (step_idx == 4'd15);
            tick();
            if (!trig[1]) cnt++;
            if (prev && step_idx == 4'd0) wraps++;
        end
        check("p0_trig1_gaps", cnt, 0);
        check("p0_wraps", wraps, 2);

        // Muted voice2 stays silent; unmuting during step 3 lets the next step 0 fire.
        run = 1'b0;
        tick();
        mute = 4'b0100;
        write_pat(2, 0, 1);
        step_period = PB'(2);
        run = 1'b1;
        hits = 0; unmuted = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (!unmuted && trig[2]) hits++;
            if (unmuted && step_strobe && step_idx == 4'd0) begin
                check("mute_release_fire", trig[2], 1);
                done = 1;
            end
            if (!unmuted && step_strobe && step_idx == 4'd3) begin
                mute = '0;
                unmuted = 1;
            end
        end
        check("muted_no_trig", hits, 0);
        check("mute_release_reached", done, 1);

        // Pattern write on the exact edge step 2 fires.
        run = 1'b0;
        tick();
        step_period = PB'(2);
        run = 1'b1;
        ph = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (ph == 0 && m_run && m_next == cyc && (m_step + 1) % NS == 2) begin
                pat_we = 1'b1; pat_voice = 2'd0; pat_step = 4'd2; pat_bit = 1'b1;
                tick();
                check("patw_edge_step", step_idx, 2);
                check("patw_edge_trig0", trig[0], 0);
                ph = 1;
            end else begin
                tick();
                if (ph == 1 && step_strobe && step_idx == 4'd2) begin
                    check("patw_next_loop_trig0", trig[0], 1);
                    done = 1;
                end
            end
        end
        check("patw_reached", done, 1);

        // Randomized traffic.
        run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) run = ~run;
            if ($urandom_range(31) == 0) step_period = PB'($urandom_range(6));
            if ($urandom_range(15) == 0) mute = NV'($urandom);
`ifdef SEQ_SWING_EN
            if ($urandom_range(7) == 0) swing = PB'($urandom_range(6));
`endif
            if ($urandom_range(3) == 0) begin
                pat_we = 1'b1; pat_voice = 2'($urandom); pat_step = 4'($urandom); pat_bit = 1'($urandom);
            end
            tick();
        end

        // Asynchronous reset during an active pulse.
        run = 1'b0;
        tick();
        mute = '0;
        write_pat(3, 0, 1);
        step_period = PB'(5);
        run = 1'b1;
        tick();
        tick();
        check("pre_rst_trig3", trig[3], 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_trig", trig, '0);
        check("rst_async_running", running, 0);
        check("rst_async_step_idx", step_idx, 0);
        model_reset();
        @(posedge mclk);
        #2 rst = 1'b0;
        step_period = PB'(1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (trig != '0) cnt++;
        end
        check("rst_pattern_cleared", cnt, 0);

`ifdef SEQ_SWING_EN
        // Swing: period 10, swing 3 gives steps at 1, 14, 21, 34.
        run = 1'b0;
        tick();
        step_period = PB'(10);
        swing = PB'(3);
        run = 1'b1;
        e0 = int'(cyc);
        offs_q.delete();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (step_strobe) offs_q.push_back(int'(cyc) - e0);
        end
        check("swing_s0", (offs_q.size() > 0) ? offs_q[0] : -1, 1);
        check("swing_s1", (offs_q.size() > 1) ? offs_q[1] : -1, 14);
        check("swing_s2", (offs_q.size() > 2) ? offs_q[2] : -1, 21);
        check("swing_s3", (offs_q.size() > 3) ? offs_q[3] : -1, 34);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
